// File: rtl/sd_cmd_rx.sv
// sd_cmd_rx: SD CMD-line response receiver.
// Waits for a start bit after rx_en rises, shifts in a 48-bit or 136-bit
// response MSB first, checks CRC7, transmission bit and end bit, and
// presents the payload on resp_data with a one-cycle resp_valid pulse.
// Build option: define SD_CMD_RX_TIMEOUT_EN to give up on a missing start
// bit after TIMEOUT cycles (timeout pulse). Without it, the receiver waits
// indefinitely and timeout is tied low.
module sd_cmd_rx #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_in,
   input  logic         rx_en,
   input  logic         long_resp,
   output logic         busy,
   output logic [127:0] resp_data,
   output logic         resp_valid,
   output logic         crc_err,
   output logic         frame_err,
   output logic         timeout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RECV = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Bits still to come after the start bit, minus one (index of next bit).
   localparam logic [7:0] LAST_SHORT = 8'd46;
   localparam logic [7:0] LAST_LONG  = 8'd134;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("sd_cmd_rx: TIMEOUT must be at least 1");
   end

   // Serial CRC7, polynomial x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = crc[6] ^ din;
      return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
   endfunction

   logic [1:0]   state_q, state_d;
   logic         rx_en_q;
   logic         long_q, long_d;
   logic [7:0]   bit_cnt_q, bit_cnt_d;
   logic [6:0]   crc_q, crc_d;
   logic [133:0] shreg_q, shreg_d;
   logic [127:0] resp_data_q, resp_data_d;
   logic         resp_valid_q, resp_valid_d;
   logic         crc_err_q, crc_err_d;
   logic         frame_err_q, frame_err_d;
   logic         timeout_q, timeout_d;

`ifdef SD_CMD_RX_TIMEOUT_EN
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

   // Next-state and datapath update for the receive FSM.
   always_comb begin
      state_d      = state_q;
      long_d       = long_q;
      bit_cnt_d    = bit_cnt_q;
      crc_d        = crc_q;
      shreg_d      = shreg_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = 1'b0;
      crc_err_d    = 1'b0;
      frame_err_d  = 1'b0;
      timeout_d    = 1'b0;
`ifdef SD_CMD_RX_TIMEOUT_EN
      wait_cnt_d   = wait_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (rx_en && !rx_en_q) begin
               state_d = ST_WAIT;
               long_d  = long_resp;
`ifdef SD_CMD_RX_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end
         end

         ST_WAIT: begin
            if (!rx_en) begin
               state_d = ST_IDLE;
            end else if (!cmd_in) begin
               // Start bit is 0, so a CRC starting from 0 is unchanged by it.
               state_d   = ST_RECV;
               bit_cnt_d = long_q ? LAST_LONG : LAST_SHORT;
               crc_d     = '0;
               shreg_d   = '0;
`ifdef SD_CMD_RX_TIMEOUT_EN
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            end
         end

         ST_RECV: begin
            if (!rx_en) begin
               state_d = ST_IDLE;
            end else begin
               // Frame bit k (k >= 1) lands at shreg_q[k-1] once the end bit arrives.
               shreg_d = {shreg_q[132:0], cmd_in};
               if (bit_cnt_q >= 8'd8 && bit_cnt_q <= 8'd127) begin
                  crc_d = crc7_step(crc_q, cmd_in);
               end
               if (bit_cnt_q == 8'd0) begin
                  state_d      = ST_DONE;
                  resp_valid_d = 1'b1;
                  crc_err_d    = (crc_q != shreg_q[6:0]);
                  frame_err_d  = (long_q ? shreg_q[133] : shreg_q[45]) | ~cmd_in;
                  resp_data_d  = long_q ? {shreg_q[126:0], 1'b0}
                                        : {90'd0, shreg_q[44:7]};
               end else begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control state, counters, CRC and outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rx_en_q      <= 1'b0;
         long_q       <= 1'b0;
         bit_cnt_q    <= '0;
         crc_q        <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         crc_err_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         timeout_q    <= 1'b0;
`ifdef SD_CMD_RX_TIMEOUT_EN
         wait_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rx_en_q      <= rx_en;
         long_q       <= long_d;
         bit_cnt_q    <= bit_cnt_d;
         crc_q        <= crc_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         crc_err_q    <= crc_err_d;
         frame_err_q  <= frame_err_d;
         timeout_q    <= timeout_d;
`ifdef SD_CMD_RX_TIMEOUT_EN
         wait_cnt_q   <= wait_cnt_d;
`endif
      end
   end

   // Frame shift register; cleared at every start bit, so no reset needed.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   assign busy       = (state_q == ST_WAIT) || (state_q == ST_RECV);
   assign resp_data  = resp_data_q;
   assign resp_valid = resp_valid_q;
   assign crc_err    = crc_err_q;
   assign frame_err  = frame_err_q;
   assign timeout    = timeout_q;

endmodule
